reg_write_arbiter: RTL

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

---
 rtl/reg_write_arbiter_pkg.sv | 12 +
 rtl/register16.sv | 37 +++
 rtl/reg_write_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/reg_write_arbiter_pkg.sv
// rtl/reg_write_arbiter_pkg.sv - shared constants and FSM state type for reg_write_arbiter
package reg_write_arbiter_pkg;

    localparam int NREQ  = 4;
    localparam int WIDTH = 16;

    typedef enum logic {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/register16.sv
// rtl/register16.sv - WIDTH-bit load-enable register with async active-low clear
//   clk   : clock
//   rst_n : async active-low clear
//   load  : capture in on the next rising edge
//   in    : data to capture
//   out   : stored value
module register16
    import reg_write_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;

    always_comb begin
        data_d = data_q;
        if (load) begin
            data_d = in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign out = data_q;

endmodule

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin write arbiter with lock bursts onto one shared register
//   clk    : clock
//   rst_n  : async active-low reset
//   req    : per-requester write request (level)
//   lock   : per-requester ownership-hold request
//   wdata  : packed write data, requester i at [i*WIDTH +: WIDTH]
//   gnt    : one-hot grant pulse per accepted write
//   q      : shared register contents
//   owner  : index of the last granted requester
//   locked : high while ownership is held
//   wr_cnt : accepted write count (wraps)
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ-1:0]       lock,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      q,
    output logic [1:0]            owner,
    output logic                  locked,
    output logic [15:0]           wr_cnt
);

    arb_state_e       state_q, state_d;
    logic [1:0]       owner_q, owner_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [15:0]      wr_cnt_q, wr_cnt_d;

    logic             reg_load;
    logic [WIDTH-1:0] reg_in;
    logic [WIDTH-1:0] wd [NREQ];
    logic [NREQ-1:0]  eligible;
    logic             found;
    logic [1:0]       pick;
    logic [1:0]       cand;

    always_comb begin
        for (int k = 0; k < NREQ; k++) begin
            wd[k] = wdata[k*WIDTH +: WIDTH];
        end
    end

    // A requester granted last cycle sits out one arbitration so a held
    // request cannot be granted twice in a row while in ARB.
    assign eligible = req & ~gnt_q;

    // Search starts just past the current owner; offset NREQ wraps back to
    // the owner itself, which is therefore considered last.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        cand  = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = owner_q + 2'(i);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        gnt_d    = '0;
        wr_cnt_d = wr_cnt_q;
        reg_load = 1'b0;
        reg_in   = '0;
        case (state_q)
            ARB: begin
                if (found) begin
                    reg_load    = 1'b1;
                    reg_in      = wd[pick];
                    gnt_d[pick] = 1'b1;
                    owner_d     = pick;
                    wr_cnt_d    = wr_cnt_q + 16'd1;
                    if (lock[pick]) begin
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (lock[owner_q]) begin
                    if (req[owner_q]) begin
                        reg_load       = 1'b1;
                        reg_in         = wd[owner_q];
                        gnt_d[owner_q] = 1'b1;
                        wr_cnt_d       = wr_cnt_q + 16'd1;
                    end
                end else begin
                    // Release costs one idle edge; owner is kept so the next
                    // arbitration resumes from owner+1.
                    state_d = ARB;
                end
            end
            default: begin
                state_d = ARB;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ARB;
            owner_q  <= 2'd3;
            gnt_q    <= '0;
            wr_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            gnt_q    <= gnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    register16 u_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (reg_load),
        .in    (reg_in),
        .out   (q)
    );

    assign gnt    = gnt_q;
    assign owner  = owner_q;
    assign locked = (state_q == LOCKED);
    assign wr_cnt = wr_cnt_q;

endmodule
